// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
// master drives operands and out_ready; slave is the adder.
interface pipelined_carry_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub,
    output out_ready,
    input  in_ready, out_valid,
    input  sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub,
    input  out_ready,
    output in_ready, out_valid,
    output sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/sub split into CHUNK-bit ripple segments,
// one register per segment, global-stall valid/ready pipe.
module pipelined_carry_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst,
  pipelined_carry_adder_if.slave io
);
  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LOL    = (STAGES - 1) * CHUNK;
  localparam int NL     = WIDTH - LOL;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             ci;

  assign adv         = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;
  assign bx          = io.sub ? ~io.b : io.b;
  assign ci          = io.sub ? ~io.cin : io.cin;

  logic [NL-1:0]    fa;
  logic [NL-1:0]    fb;
  logic             fc;
  logic             fv;
  logic [NL:0]      ft;
  logic [WIDTH-1:0] fsn;

  if (STAGES == 1) begin : g_one
    assign fa  = io.a;
    assign fb  = bx;
    assign fc  = ci;
    assign fv  = io.in_valid;
    assign fsn = ft[NL-1:0];
  end else begin : g_pipe
    // Operand bits still to be added travel right-aligned,
    // finished sum bits accumulate at the bottom.
    for (genvar k = 0; k < STAGES - 1; k++) begin : stg
      localparam int LO = k * CHUNK;
      localparam int HI = LO + CHUNK;
      localparam int RW = WIDTH - LO;

      logic [RW-1:0]       ia;
      logic [RW-1:0]       ib;
      logic                ic;
      logic                iv;
      logic [CHUNK:0]      t;
      logic [HI-1:0]       ns;
      logic                rv;
      logic                rc;
      logic [HI-1:0]       rs;
      logic [WIDTH-HI-1:0] ra;
      logic [WIDTH-HI-1:0] rb;

      if (k == 0) begin : src
        assign ia = io.a;
        assign ib = bx;
        assign ic = ci;
        assign iv = io.in_valid;
        assign ns = t[CHUNK-1:0];
      end else begin : src
        assign ia = stg[k-1].ra;
        assign ib = stg[k-1].rb;
        assign ic = stg[k-1].rc;
        assign iv = stg[k-1].rv;
        assign ns = {t[CHUNK-1:0], stg[k-1].rs};
      end

      assign t = {1'b0, ia[CHUNK-1:0]}
               + {1'b0, ib[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, ic};

      always_ff @(posedge clk) begin
        if (rst) begin
          rv <= 1'b0;
          rc <= 1'b0;
          rs <= '0;
          ra <= '0;
          rb <= '0;
        end else if (adv) begin
          rv <= iv;
          rc <= t[CHUNK];
          rs <= ns;
          ra <= ia[RW-1:CHUNK];
          rb <= ib[RW-1:CHUNK];
        end
      end
    end

    assign fa  = stg[STAGES-2].ra;
    assign fb  = stg[STAGES-2].rb;
    assign fc  = stg[STAGES-2].rc;
    assign fv  = stg[STAGES-2].rv;
    assign fsn = {ft[NL-1:0], stg[STAGES-2].rs};
  end

  assign ft = {1'b0, fa} + {1'b0, fb} + {{NL{1'b0}}, fc};

  logic             ov_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_r   <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (adv) begin
      ov_r   <= fv;
      sum_r  <= fsn;
      cout_r <= ft[NL];
      ovf_r  <= (fa[NL-1] == fb[NL-1])
             && (ft[NL-1] != fa[NL-1]);
    end
  end

  assign io.out_valid = ov_r;
  assign io.sum       = sum_r;
  assign io.cout      = cout_r;
  assign io.ovf       = ovf_r;
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench: 8/4 and 32/32 adders against an integer-arithmetic
// model with a latency/backpressure scoreboard.
module tb_pipelined_carry_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_carry_adder_if #(.WIDTH(8))  i8 ();
  pipelined_carry_adder_if #(.WIDTH(32)) i32 ();

  pipelined_carry_adder #(.WIDTH(8), .CHUNK(4)) d8 (
    .clk (clk),
    .rst (rst),
    .io  (i8.slave)
  );

  pipelined_carry_adder #(.WIDTH(32), .CHUNK(32)) d32 (
    .clk (clk),
    .rst (rst),
    .io  (i32.slave)
  );

  typedef struct {
    logic [33:0] r;
    int          age;
  } ent_t;

  ent_t q8[$];
  ent_t q32[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from signed/unsigned integer arithmetic
  function automatic logic [33:0] model(
    input int w, input logic [31:0] a, input logic [31:0] b,
    input logic c, input logic s);
    longint m, ua, ub, sa, sb, u, r;
    logic [31:0] sm;
    logic co, ov;
    m  = 64'sd1 <<< w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    u  = s ? ua - ub - longint'(c) : ua + ub + longint'(c);
    r  = s ? sa - sb - longint'(c) : sa + sb + longint'(c);
    sm = 32'(u & (m - 1));
    co = s ? (u >= 0) : (u >= m);
    ov = (r >= m / 2) || (r < -(m / 2));
    return {ov, co, sm};
  endfunction

  task automatic step_unit(
    input string n, input int w, input int st,
    ref ent_t q[$],
    input logic ov, input logic ir,
    input logic iv, input logic ordy,
    input logic co, input logic of,
    input logic ci, input logic sb,
    input logic [31:0] sm,
    input logic [31:0] a, input logic [31:0] b);
    logic mv, madv;
    mv   = (q.size() > 0) && (q[0].age >= st);
    madv = !mv || ordy;
    chk({n, ".valid"}, 64'(ov), 64'(mv));
    chk({n, ".ready"}, 64'(ir), 64'(madv));
    if (mv)
      chk({n, ".res"}, 64'({of, co, sm}), 64'(q[0].r));
    if (rst) begin
      q.delete();
    end else if (madv) begin
      if (mv && ordy) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (iv) q.push_back('{model(w, a, b, ci, sb), 1});
    end
  endtask

  task automatic tick();
    #1;
    step_unit("u8", 8, 2, q8,
      i8.out_valid, i8.in_ready, i8.in_valid, i8.out_ready,
      i8.cout, i8.ovf, i8.cin, i8.sub,
      32'(i8.sum), 32'(i8.a), 32'(i8.b));
    step_unit("u32", 32, 1, q32,
      i32.out_valid, i32.in_ready, i32.in_valid, i32.out_ready,
      i32.cout, i32.ovf, i32.cin, i32.sub,
      i32.sum, i32.a, i32.b);
    @(negedge clk);
  endtask

  task automatic beat8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic s);
    i8.in_valid = 1'b1;
    i8.a = a;
    i8.b = b;
    i8.cin = c;
    i8.sub = s;
  endtask

  initial begin
    rst = 1'b1;
    i8.in_valid = 0; i8.a = 0; i8.b = 0;
    i8.cin = 0; i8.sub = 0; i8.out_ready = 1;
    i32.in_valid = 0; i32.a = 0; i32.b = 0;
    i32.cin = 0; i32.sub = 0; i32.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(i8.out_valid), 64'(0));
    chk("rst.sum", 64'(i8.sum), 64'(0));
    chk("rst.cout", 64'(i8.cout), 64'(0));
    chk("rst.ovf", 64'(i8.ovf), 64'(0));
    chk("rst.valid32", 64'(i32.out_valid), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst.ready", 64'(i8.in_ready), 64'(1));
    @(negedge clk);

    beat8(8'hFF, 8'h01, 0, 0);
    tick();
    i8.in_valid = 0;
    chk("add.lat1", 64'(i8.out_valid), 64'(0));
    tick();
    chk("add.v", 64'(i8.out_valid), 64'(1));
    chk("add.res", 64'({i8.ovf, i8.cout, i8.sum}),
        64'({1'b0, 1'b1, 8'h00}));
    tick();

    beat8(8'h80, 8'h01, 0, 1);
    tick();
    beat8(8'h00, 8'h01, 0, 1);
    tick();
    i8.in_valid = 0;
    chk("sub1", 64'({i8.ovf, i8.cout, i8.sum}),
        64'({1'b1, 1'b1, 8'h7F}));
    tick();
    chk("sub2", 64'({i8.ovf, i8.cout, i8.sum}),
        64'({1'b0, 1'b0, 8'hFF}));
    tick();

    i8.out_ready = 0;
    beat8(8'h01, 8'h01, 0, 0);
    tick();
    beat8(8'h02, 8'h02, 0, 0);
    tick();
    beat8(8'h03, 8'h03, 0, 0);
    chk("bp.full", 64'(i8.in_ready), 64'(0));
    repeat (3) tick();
    chk("bp.hold", 64'(i8.sum), 64'(8'h02));
    i8.out_ready = 1;
    tick();
    i8.in_valid = 0;
    chk("bp.2nd", 64'(i8.sum), 64'(8'h04));
    repeat (3) tick();

    for (int i = 0; i < 4; i++) begin
      beat8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if (i == 2) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    i8.in_valid = 0;
    chk("rst.mid", 64'(i8.out_valid), 64'(0));
    repeat (4) tick();

    i32.in_valid = 1; i32.a = 32'hFFFF_FFFF;
    i32.b = 32'h1; i32.cin = 0; i32.sub = 0;
    tick();
    i32.in_valid = 0;
    chk("w32.lat", 64'(i32.out_valid), 64'(1));
    chk("w32.res", 64'({i32.ovf, i32.cout, i32.sum}),
        64'({1'b0, 1'b1, 32'h0}));
    tick();

    for (int i = 0; i < 300; i++) begin
      beat8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      i8.in_valid = ($urandom_range(3) != 0);
      i8.out_ready = ($urandom_range(9) < 7);
      i32.in_valid = ($urandom_range(3) != 0);
      i32.a = $urandom; i32.b = $urandom;
      i32.cin = 1'($urandom); i32.sub = 1'($urandom);
      i32.out_ready = ($urandom_range(9) < 7);
      tick();
    end
    i8.in_valid = 0; i8.out_ready = 1;
    i32.in_valid = 0; i32.out_ready = 1;
    repeat (5) tick();
    chk("drain8", 64'(q8.size()), 64'(0));
    chk("drain32", 64'(q32.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
